n1_ir_seq: RTL and testbench



---
 rtl/n1_ir_seq_pkg.sv | 27 ++
 rtl/n1_ir_seq_tmo.sv | 29 ++
 rtl/n1_ir_seq.sv | 192 +++++++++++++++++++
 tb/tb_n1_ir_seq.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/n1_ir_seq_pkg.sv
// n1_ir_seq_pkg: shared types and constants for the N1 IR sequencer.
//   state_e     - sequencer FSM states
//   cof_e       - change-of-flow tag carried into the next opcode fetch
//   TMO_CYC_DEF - default bus timeout in cycles
package n1_ir_seq_pkg;
    localparam int TMO_CYC_DEF = 15;

    typedef enum logic [3:0] {
        ST_BOOT,
        ST_FETCH,
        ST_WAIT,
        ST_EXEC,
        ST_MEM,
        ST_MWAIT,
        ST_ISR,
        ST_EXPEND,
        ST_ABORT
    } state_e;

    typedef enum logic [2:0] {
        COF_NONE,
        COF_JMP,
        COF_CAL,
        COF_BRA,
        COF_EOW
    } cof_e;
endpackage

// File: rtl/n1_ir_seq_tmo.sv
// n1_ir_seq_tmo: saturating bus timeout counter.
//   clk_i, sync_rst_i - clock, synchronous active-high reset
//   clr_i             - return the count to zero (takes priority over en_i)
//   en_i              - count one cycle
//   exp_o             - count has reached TMO_CYC-1
module n1_ir_seq_tmo #(
    parameter int TMO_CYC = 15
) (
    input  logic clk_i,
    input  logic sync_rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic exp_o
);
    localparam int W = $clog2(TMO_CYC);
    localparam logic [W-1:0] CNT_MAX = W'(TMO_CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign exp_o = (cnt_q == CNT_MAX);

    // Saturate at the limit instead of wrapping.
    always_comb cnt_d = clr_i ? '0 : (en_i && !exp_o) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/n1_ir_seq.sv
// n1_ir_seq: instruction-register sequencer for the N1 core.
//   clk_i, sync_rst_i     - clock, synchronous active-high reset
//   pbus_*_o / pbus_*_i   - Wishbone program bus master (cyc/stb/we, data and COF tags, ack/stall)
//   ir2fc_*_i             - IR decode of the current opcode
//   prs2fc_ps0_zero_i     - PS0 == 0, branch taken
//   irq_req_i             - level interrupt request, sampled at opcode-fetch ack
//   fc2ir_*_o             - single-cycle IR controls
//   fc2pagu_adv_o         - advance PC
//   fc_rty_o              - bus cycle aborted on timeout, reissue follows
module n1_ir_seq
    import n1_ir_seq_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk_i,
    input  logic sync_rst_i,
    output logic pbus_cyc_o,
    output logic pbus_stb_o,
    output logic pbus_we_o,
    output logic pbus_tga_dat_o,
    output logic pbus_tga_cof_jmp_o,
    output logic pbus_tga_cof_cal_o,
    output logic pbus_tga_cof_bra_o,
    output logic pbus_tga_cof_eow_o,
    input  logic pbus_ack_i,
    input  logic pbus_stall_i,
    input  logic ir2fc_eow_i,
    input  logic ir2fc_jump_or_call_i,
    input  logic ir2fc_bra_i,
    input  logic ir2fc_isr_i,
    input  logic ir2fc_scyc_i,
    input  logic ir2fc_mem_i,
    input  logic ir2fc_mem_rd_i,
    input  logic prs2fc_ps0_zero_i,
    input  logic irq_req_i,
    output logic fc2ir_capture_o,
    output logic fc2ir_stash_o,
    output logic fc2ir_expend_o,
    output logic fc2ir_force_0call_o,
    output logic fc2ir_force_isr_o,
    output logic fc2ir_force_nop_o,
    output logic fc2pagu_adv_o,
    output logic fc_rty_o
);
    state_e state_q, state_d;
    cof_e   tag_q, tag_d;
    logic   we_q, we_d;
    logic   ret_mem_q, ret_mem_d;
    logic   tmo_en, tmo_clr, tmo_exp;

    // The ISR launcher and single-cycle opcodes need no special sequencing.
    logic unused_ok;
    assign unused_ok = &{1'b0, ir2fc_isr_i, ir2fc_scyc_i};

    // Any state change restarts the timeout window; an ack beats a same-cycle expiry.
    assign tmo_clr = (state_d != state_q) || pbus_ack_i;

    n1_ir_seq_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .clr_i      (tmo_clr),
        .en_i       (tmo_en),
        .exp_o      (tmo_exp)
    );

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q   <= ST_BOOT;
            tag_q     <= COF_NONE;
            we_q      <= 1'b0;
            ret_mem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            we_q      <= we_d;
            ret_mem_q <= ret_mem_d;
        end
    end

    // Everything is held quiet while reset is asserted, so no IR pulse or bus
    // request escapes in the reset cycle itself.
    always_comb begin
        state_d             = state_q;
        tag_d               = tag_q;
        we_d                = we_q;
        ret_mem_d           = ret_mem_q;
        tmo_en              = 1'b0;
        pbus_cyc_o          = 1'b0;
        pbus_stb_o          = 1'b0;
        pbus_we_o           = 1'b0;
        pbus_tga_dat_o      = 1'b0;
        pbus_tga_cof_jmp_o  = 1'b0;
        pbus_tga_cof_cal_o  = 1'b0;
        pbus_tga_cof_bra_o  = 1'b0;
        pbus_tga_cof_eow_o  = 1'b0;
        fc2ir_capture_o     = 1'b0;
        fc2ir_stash_o       = 1'b0;
        fc2ir_expend_o      = 1'b0;
        fc2ir_force_0call_o = 1'b0;
        fc2ir_force_isr_o   = 1'b0;
        fc2ir_force_nop_o   = 1'b0;
        fc2pagu_adv_o       = 1'b0;
        fc_rty_o            = 1'b0;
        if (!sync_rst_i) begin
            case (state_q)
                ST_BOOT: begin
                    fc2ir_force_0call_o = 1'b1;
                    tag_d               = COF_CAL;
                    state_d             = ST_FETCH;
                end
                ST_FETCH: begin
                    pbus_cyc_o         = 1'b1;
                    pbus_stb_o         = 1'b1;
                    pbus_tga_cof_jmp_o = (tag_q == COF_JMP);
                    pbus_tga_cof_cal_o = (tag_q == COF_CAL);
                    pbus_tga_cof_bra_o = (tag_q == COF_BRA);
                    pbus_tga_cof_eow_o = (tag_q == COF_EOW);
                    tmo_en             = 1'b1;
                    if (!pbus_stall_i) begin
                        state_d = ST_WAIT;
                    end else if (tmo_exp) begin
                        state_d   = ST_ABORT;
                        ret_mem_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    pbus_cyc_o = 1'b1;
                    tmo_en     = 1'b1;
                    if (pbus_ack_i) begin
                        fc2ir_capture_o   = 1'b1;
                        fc2pagu_adv_o     = 1'b1;
                        fc2ir_stash_o     = irq_req_i;
                        fc2ir_force_isr_o = irq_req_i;
                        state_d           = irq_req_i ? ST_ISR : ST_EXEC;
                    end else if (tmo_exp) begin
                        state_d   = ST_ABORT;
                        ret_mem_d = 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (ir2fc_mem_i) begin
                        state_d = ST_MEM;
                        we_d    = !ir2fc_mem_rd_i;
                        tag_d   = COF_NONE;
                    end else begin
                        state_d = ST_FETCH;
                        tag_d   = ir2fc_jump_or_call_i ? (ir2fc_eow_i ? COF_JMP : COF_CAL) :
                                  ir2fc_bra_i          ? (prs2fc_ps0_zero_i ? COF_BRA : COF_NONE) :
                                  ir2fc_eow_i          ? COF_EOW : COF_NONE;
                    end
                end
                ST_MEM: begin
                    pbus_cyc_o     = 1'b1;
                    pbus_stb_o     = 1'b1;
                    pbus_tga_dat_o = 1'b1;
                    pbus_we_o      = we_q;
                    tmo_en         = 1'b1;
                    if (!pbus_stall_i) begin
                        state_d = ST_MWAIT;
                    end else if (tmo_exp) begin
                        state_d   = ST_ABORT;
                        ret_mem_d = 1'b1;
                    end
                end
                ST_MWAIT: begin
                    pbus_cyc_o     = 1'b1;
                    pbus_tga_dat_o = 1'b1;
                    pbus_we_o      = we_q;
                    tmo_en         = 1'b1;
                    if (pbus_ack_i) begin
                        state_d = ST_FETCH;
                        tag_d   = ir2fc_eow_i ? COF_EOW : COF_NONE;
                    end else if (tmo_exp) begin
                        state_d   = ST_ABORT;
                        ret_mem_d = 1'b1;
                    end
                end
                ST_ISR:    state_d = ST_EXPEND;
                ST_EXPEND: begin
                    fc2ir_expend_o = 1'b1;
                    state_d        = ST_EXEC;
                end
                ST_ABORT: begin
                    // Tags and we are untouched, so the reissue is identical.
                    fc_rty_o = 1'b1;
                    state_d  = ret_mem_q ? ST_MEM : ST_FETCH;
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_n1_ir_seq.sv
// tb_n1_ir_seq: directed self-checking bench for n1_ir_seq (timeout set to 4 cycles).
module tb_n1_ir_seq;
    localparam logic [15:0] CYC = 16'h8000, STB = 16'h4000, WE  = 16'h2000, DAT = 16'h1000;
    localparam logic [15:0] JMP = 16'h0800, CAL = 16'h0400, BRA = 16'h0200, EOW = 16'h0100;
    localparam logic [15:0] CAP = 16'h0080, STA = 16'h0040, EXP = 16'h0020, F0  = 16'h0010;
    localparam logic [15:0] FI  = 16'h0008, FN  = 16'h0004, ADV = 16'h0002, RTY = 16'h0001;

    logic clk_i = 1'b0;
    logic sync_rst_i = 1'b1;
    logic pbus_cyc_o, pbus_stb_o, pbus_we_o, pbus_tga_dat_o;
    logic pbus_tga_cof_jmp_o, pbus_tga_cof_cal_o, pbus_tga_cof_bra_o, pbus_tga_cof_eow_o;
    logic pbus_ack_i = 1'b0, pbus_stall_i = 1'b0;
    logic ir2fc_eow_i = 1'b0, ir2fc_jump_or_call_i = 1'b0, ir2fc_bra_i = 1'b0, ir2fc_isr_i = 1'b0;
    logic ir2fc_scyc_i = 1'b0, ir2fc_mem_i = 1'b0, ir2fc_mem_rd_i = 1'b0;
    logic prs2fc_ps0_zero_i = 1'b0, irq_req_i = 1'b0;
    logic fc2ir_capture_o, fc2ir_stash_o, fc2ir_expend_o, fc2ir_force_0call_o;
    logic fc2ir_force_isr_o, fc2ir_force_nop_o, fc2pagu_adv_o, fc_rty_o;
    logic [15:0] obs;
    int n_cmp = 0, n_bad = 0;

    always #5 clk_i = ~clk_i;

    n1_ir_seq #(.TMO_CYC(4)) dut (
        .clk_i                (clk_i),
        .sync_rst_i           (sync_rst_i),
        .pbus_cyc_o           (pbus_cyc_o),
        .pbus_stb_o           (pbus_stb_o),
        .pbus_we_o            (pbus_we_o),
        .pbus_tga_dat_o       (pbus_tga_dat_o),
        .pbus_tga_cof_jmp_o   (pbus_tga_cof_jmp_o),
        .pbus_tga_cof_cal_o   (pbus_tga_cof_cal_o),
        .pbus_tga_cof_bra_o   (pbus_tga_cof_bra_o),
        .pbus_tga_cof_eow_o   (pbus_tga_cof_eow_o),
        .pbus_ack_i           (pbus_ack_i),
        .pbus_stall_i         (pbus_stall_i),
        .ir2fc_eow_i          (ir2fc_eow_i),
        .ir2fc_jump_or_call_i (ir2fc_jump_or_call_i),
        .ir2fc_bra_i          (ir2fc_bra_i),
        .ir2fc_isr_i          (ir2fc_isr_i),
        .ir2fc_scyc_i         (ir2fc_scyc_i),
        .ir2fc_mem_i          (ir2fc_mem_i),
        .ir2fc_mem_rd_i       (ir2fc_mem_rd_i),
        .prs2fc_ps0_zero_i    (prs2fc_ps0_zero_i),
        .irq_req_i            (irq_req_i),
        .fc2ir_capture_o      (fc2ir_capture_o),
        .fc2ir_stash_o        (fc2ir_stash_o),
        .fc2ir_expend_o       (fc2ir_expend_o),
        .fc2ir_force_0call_o  (fc2ir_force_0call_o),
        .fc2ir_force_isr_o    (fc2ir_force_isr_o),
        .fc2ir_force_nop_o    (fc2ir_force_nop_o),
        .fc2pagu_adv_o        (fc2pagu_adv_o),
        .fc_rty_o             (fc_rty_o)
    );

    assign obs = {pbus_cyc_o, pbus_stb_o, pbus_we_o, pbus_tga_dat_o,
                  pbus_tga_cof_jmp_o, pbus_tga_cof_cal_o, pbus_tga_cof_bra_o, pbus_tga_cof_eow_o,
                  fc2ir_capture_o, fc2ir_stash_o, fc2ir_expend_o, fc2ir_force_0call_o,
                  fc2ir_force_isr_o, fc2ir_force_nop_o, fc2pagu_adv_o, fc_rty_o};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %04h expected %04h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply ack/stall, check outputs mid-cycle, advance past the edge.
    task automatic cy(input string tag, input logic ack, input logic stall, input logic [15:0] exp);
        pbus_ack_i   = ack;
        pbus_stall_i = stall;
        #1;
        chk(tag, obs, exp);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        cy("reset", 1'b0, 1'b0, 16'h0000);
        sync_rst_i = 1'b0;
        cy("boot", 1'b0, 1'b0, F0);
        cy("fetch0_cal", 1'b0, 1'b0, CYC | STB | CAL);
        cy("wait0_ack", 1'b1, 1'b0, CYC | CAP | ADV);
        ir2fc_mem_i = 1'b1;
        ir2fc_mem_rd_i = 1'b0;
        cy("exec_mem_wr", 1'b0, 1'b0, 16'h0000);
        cy("mem_stall1", 1'b0, 1'b1, CYC | STB | WE | DAT);
        cy("mem_stall2", 1'b0, 1'b1, CYC | STB | WE | DAT);
        cy("mem_go", 1'b0, 1'b0, CYC | STB | WE | DAT);
        cy("mwait_ack", 1'b1, 1'b0, CYC | WE | DAT);
        ir2fc_mem_i = 1'b0;
        cy("fetch_after_mem", 1'b0, 1'b0, CYC | STB);
        cy("wait1_ack", 1'b1, 1'b0, CYC | CAP | ADV);
        ir2fc_bra_i = 1'b1;
        prs2fc_ps0_zero_i = 1'b1;
        cy("exec_bra_taken", 1'b0, 1'b0, 16'h0000);
        ir2fc_bra_i = 1'b0;
        cy("fetch_bra", 1'b0, 1'b0, CYC | STB | BRA);
        cy("wait2_ack", 1'b1, 1'b0, CYC | CAP | ADV);
        ir2fc_bra_i = 1'b1;
        prs2fc_ps0_zero_i = 1'b0;
        cy("exec_bra_not", 1'b0, 1'b0, 16'h0000);
        ir2fc_bra_i = 1'b0;
        cy("fetch_bra_not", 1'b0, 1'b0, CYC | STB);
        irq_req_i = 1'b1;
        cy("wait_irq_ack", 1'b1, 1'b0, CYC | CAP | STA | FI | ADV);
        irq_req_i = 1'b0;
        ir2fc_isr_i = 1'b1;
        cy("isr", 1'b0, 1'b0, 16'h0000);
        ir2fc_isr_i = 1'b0;
        cy("expend", 1'b0, 1'b0, EXP);
        ir2fc_jump_or_call_i = 1'b1;
        ir2fc_eow_i = 1'b0;
        cy("exec_call", 1'b0, 1'b0, 16'h0000);
        ir2fc_jump_or_call_i = 1'b0;
        cy("fetch_cal", 1'b0, 1'b0, CYC | STB | CAL);
        cy("tmo_wait0", 1'b0, 1'b0, CYC);
        cy("tmo_wait1", 1'b0, 1'b0, CYC);
        cy("tmo_wait2", 1'b0, 1'b0, CYC);
        cy("tmo_wait3", 1'b0, 1'b0, CYC);
        cy("abort", 1'b0, 1'b0, RTY);
        cy("refetch_cal", 1'b0, 1'b0, CYC | STB | CAL);
        cy("refetch_ack", 1'b1, 1'b0, CYC | CAP | ADV);
        ir2fc_jump_or_call_i = 1'b1;
        ir2fc_eow_i = 1'b1;
        cy("exec_jump", 1'b0, 1'b0, 16'h0000);
        ir2fc_jump_or_call_i = 1'b0;
        ir2fc_eow_i = 1'b0;
        cy("fetch_jmp", 1'b0, 1'b0, CYC | STB | JMP);
        cy("late_wait0", 1'b0, 1'b0, CYC);
        cy("late_wait1", 1'b0, 1'b0, CYC);
        cy("late_wait2", 1'b0, 1'b0, CYC);
        cy("ack_at_tmo", 1'b1, 1'b0, CYC | CAP | ADV);
        ir2fc_eow_i = 1'b1;
        cy("exec_eow", 1'b0, 1'b0, 16'h0000);
        ir2fc_eow_i = 1'b0;
        cy("fetch_eow", 1'b0, 1'b0, CYC | STB | EOW);
        cy("wait3_ack", 1'b1, 1'b0, CYC | CAP | ADV);
        ir2fc_mem_i = 1'b1;
        ir2fc_mem_rd_i = 1'b1;
        ir2fc_eow_i = 1'b1;
        cy("exec_mem_rd_prio", 1'b0, 1'b0, 16'h0000);
        cy("mem_rd", 1'b0, 1'b0, CYC | STB | DAT);
        cy("mwait_rd", 1'b0, 1'b0, CYC | DAT);
        sync_rst_i = 1'b1;
        cy("mwait_reset", 1'b1, 1'b0, 16'h0000);
        sync_rst_i = 1'b0;
        ir2fc_mem_i = 1'b0;
        ir2fc_mem_rd_i = 1'b0;
        ir2fc_eow_i = 1'b0;
        cy("reboot", 1'b0, 1'b0, F0);
        cy("refetch_boot", 1'b0, 1'b0, CYC | STB | CAL);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
